qspi_slave_axi_m: RTL

- QSPI target (responder) for the external side of our flash-style QSPI link; the protocol end opposite hs_spi_master_axi_m.
- Decodes command/address/data frames from an external QSPI master and issues the matching single-beat AXI4-lite master transaction into the fabric.
- Oversamples SCK/CSn/MOSI in the aclk domain; no SCK-domain logic.

---
 rtl/qspi_pkg.sv | 25 ++
 rtl/axi4_lite_if.sv | 41 ++++
 rtl/qspi_slave_axi_m_sync.sv | 46 ++++
 rtl/qspi_slave_axi_m.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// qspi_pkg: command codes, error pattern and FSM states for the QSPI link.
// Shared by qspi_slave_axi_m and hs_spi_master_axi_m.
package qspi_pkg;

    localparam logic [7:0]  CMD_WRITE   = 8'h02;
    localparam logic [7:0]  CMD_READ    = 8'h0B;
    localparam logic [7:0]  CMD_STAT    = 8'h05;
    localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;
    localparam int          QSPI_ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_DUMMY,
        S_RDATA,
        S_DROP
    } qspi_state_e;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-lite bundle with master and slave views.
interface axi4_lite_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport m (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport s (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/qspi_slave_axi_m_sync.sv
// qspi_slv_sync: two-flop synchronisers for SCK/CSn/MOSI plus edge pulses.
module qspi_slv_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sck,
    input  logic         csn,
    input  logic [W-1:0] mosi,
    output logic         sck_rise,
    output logic         sck_fall,
    output logic         csn_fall,
    output logic         csn_rise,
    output logic         csn_s,
    output logic [W-1:0] mosi_s
);
    logic [2:0]        sck_q, sck_d;
    logic [2:0]        csn_q, csn_d;
    logic [1:0][W-1:0] mosi_q, mosi_d;

    always_comb begin
        sck_d  = {sck_q[1:0], sck};
        csn_d  = {csn_q[1:0], csn};
        mosi_d = {mosi_q[0], mosi};
    end

    // CSn resets high so a deasserted line never looks like a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            csn_q  <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= sck_d;
            csn_q  <= csn_d;
            mosi_q <= mosi_d;
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign csn_fall = ~csn_q[1] & csn_q[2];
    assign csn_rise = csn_q[1] & ~csn_q[2];
    assign csn_s    = csn_q[1];
    assign mosi_s   = mosi_q[1];
endmodule

// File: rtl/qspi_slave_axi_m.sv
// qspi_slave_axi_m: QSPI target turning cmd/addr/data frames into AXI4-lite beats.
// Define QSPI_SLV_STATS_EN for transfer counters readable with cmd 0x05.
module qspi_slave_axi_m
    import qspi_pkg::*;
#(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int SPI_W        = 4,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi4_lite_if.m           bus,
    input  logic             SCK,
    input  logic             CSn,
    input  logic [SPI_W-1:0] MOSI,
    output logic [SPI_W-1:0] MISO,
    output logic             MISO_oe,
    output logic             busy,
    output logic             err
);
    localparam logic [5:0] N_CMD  = 6'(8 / SPI_W);
    localparam logic [5:0] N_ADDR = 6'(QSPI_ADDR_W / SPI_W);
    localparam logic [5:0] N_DATA = 6'(DW / SPI_W);
    localparam logic [5:0] N_DUM  = 6'(DUMMY_CYCLES);

    logic             sck_rise, sck_fall, csn_fall, csn_rise, csn_s;
    logic [SPI_W-1:0] mosi_s;

    qspi_slv_sync #(.W(SPI_W)) u_sync (
        .clk      (aclk),
        .rst_n    (aresetn),
        .sck      (SCK),
        .csn      (CSn),
        .mosi     (MOSI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .csn_fall (csn_fall),
        .csn_rise (csn_rise),
        .csn_s    (csn_s),
        .mosi_s   (mosi_s)
    );

    qspi_state_e   state_q, state_d;
    logic [5:0]    cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0] sh_q, sh_d, shifted;
    logic [7:0]    cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, mo_q, mo_d, rdata_q, rdata_d;
    logic          oe_q, oe_d, err_q, err_d;
    logic          awv_q, awv_d, wv_q, wv_d, bready_q, bready_d;
    logic          arv_q, arv_d, rready_q, rready_d, rd_ok_q, rd_ok_d;
    logic          pend;
`ifdef QSPI_SLV_STATS_EN
    logic [11:0]   nwr_q, nwr_d, nrd_q, nrd_d;
    logic [7:0]    nab_q, nab_d;
`endif

    assign shifted = {sh_q[DW-SPI_W-1:0], mosi_s};
    assign cnt_inc = cnt_q + 6'd1;
    assign pend    = awv_q | wv_q | bready_q | arv_q | rready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mo_d     = mo_q;
        oe_d     = oe_q;
        err_d    = 1'b0;
        awv_d    = awv_q & ~bus.awready;
        wv_d     = wv_q & ~bus.wready;
        bready_d = bready_q;
        arv_d    = arv_q & ~bus.arready;
        rready_d = rready_q;
        rdata_d  = rdata_q;
        rd_ok_d  = rd_ok_q;
`ifdef QSPI_SLV_STATS_EN
        nwr_d    = nwr_q;
        nrd_d    = nrd_q;
        nab_d    = nab_q;
`endif
        if ((awv_q | wv_q) && !awv_d && !wv_d) bready_d = 1'b1;
        if (bready_q && bus.bvalid) begin
            bready_d = 1'b0;
            if (bus.bresp != 2'b00) err_d = 1'b1;
`ifdef QSPI_SLV_STATS_EN
            nwr_d = sat_inc12(nwr_q);
`endif
        end
        // late responses still land here; rd_ok is cleared per read so they are dropped
        if (rready_q && bus.rvalid) begin
            rready_d = 1'b0;
            rdata_d  = bus.rdata;
            rd_ok_d  = 1'b1;
            if (bus.rresp != 2'b00) err_d = 1'b1;
`ifdef QSPI_SLV_STATS_EN
            nrd_d = sat_inc12(nrd_q);
`endif
        end
        if (state_q != S_IDLE && (csn_s || csn_rise)) begin
`ifdef QSPI_SLV_STATS_EN
            if (state_q == S_WDATA && nab_q != 8'hFF) nab_d = nab_q + 8'd1;
`endif
            state_d = S_IDLE;
            oe_d    = 1'b0;
            mo_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (csn_fall) begin
                    cnt_d = '0;
                    if (pend) begin
                        state_d = S_DROP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: if (sck_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_CMD) begin
                        cnt_d   = '0;
                        cmd_d   = shifted[7:0];
                        state_d = S_DROP;
                        if (shifted[7:0] == CMD_WRITE || shifted[7:0] == CMD_READ)
                            state_d = S_ADDR;
`ifdef QSPI_SLV_STATS_EN
                        if (shifted[7:0] == CMD_STAT) state_d = S_DUMMY;
`endif
                    end
                end
                S_ADDR: if (sck_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_ADDR) begin
                        cnt_d  = '0;
                        addr_d = shifted[AW-1:0];
                        if (cmd_q == CMD_WRITE) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d  = S_DUMMY;
                            arv_d    = 1'b1;
                            rready_d = 1'b1;
                            rd_ok_d  = 1'b0;
                        end
                    end
                end
                S_WDATA: if (sck_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_DATA) begin
                        wdata_d = shifted;
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                        state_d = S_DROP;
                    end
                end
                S_DUMMY: if (sck_rise) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_DUM) begin
                        cnt_d   = '0;
                        state_d = S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (sck_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                            if (rd_ok_d) begin
                                mo_d = rdata_d;
                            end else begin
                                mo_d  = ERR_PATTERN;
                                err_d = 1'b1;
                            end
`ifdef QSPI_SLV_STATS_EN
                            if (cmd_q == CMD_STAT) begin
                                mo_d  = {nab_q, nwr_q, nrd_q};
                                err_d = 1'b0;
                            end
`endif
                        end else begin
                            mo_d = {mo_q[DW-SPI_W-1:0], {SPI_W{1'b0}}};
                        end
                    end
                    if (sck_rise) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == N_DATA) state_d = S_DROP;
                    end
                end
                S_DROP: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mo_q     <= '0;
            rdata_q  <= '0;
            oe_q     <= 1'b0;
            err_q    <= 1'b0;
            awv_q    <= 1'b0;
            wv_q     <= 1'b0;
            bready_q <= 1'b0;
            arv_q    <= 1'b0;
            rready_q <= 1'b0;
            rd_ok_q  <= 1'b0;
`ifdef QSPI_SLV_STATS_EN
            nwr_q    <= '0;
            nrd_q    <= '0;
            nab_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mo_q     <= mo_d;
            rdata_q  <= rdata_d;
            oe_q     <= oe_d;
            err_q    <= err_d;
            awv_q    <= awv_d;
            wv_q     <= wv_d;
            bready_q <= bready_d;
            arv_q    <= arv_d;
            rready_q <= rready_d;
            rd_ok_q  <= rd_ok_d;
`ifdef QSPI_SLV_STATS_EN
            nwr_q    <= nwr_d;
            nrd_q    <= nrd_d;
            nab_q    <= nab_d;
`endif
        end
    end

    assign bus.awvalid = awv_q;
    assign bus.awaddr  = addr_q;
    assign bus.awprot  = 3'b000;
    assign bus.wvalid  = wv_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = '1;
    assign bus.bready  = bready_q;
    assign bus.arvalid = arv_q;
    assign bus.araddr  = addr_q;
    assign bus.arprot  = 3'b000;
    assign bus.rready  = rready_q;

    assign MISO    = mo_q[DW-1 -: SPI_W];
    assign MISO_oe = oe_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE) | pend;
endmodule
